// File: rtl/slip_tx_enc.sv
// SLIP (RFC1055) frame encoder: pops packet bytes from a FIFO read port, escapes
// 0xC0/0xDB, delimits frames with END (0xC0) and drives a valid/ready byte stream.
module slip_tx_enc #(
   parameter bit          LEAD_END  = 1'b1,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           in_data,
   input  logic                 in_last,
   input  logic                 in_empty,
   output logic                 in_ena,
   output logic [7:0]           out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] frm_cnt
);

   localparam logic [7:0] END_B     = 8'hC0;
   localparam logic [7:0] ESC_B     = 8'hDB;
   localparam logic [7:0] ESC_END_B = 8'hDC;
   localparam logic [7:0] ESC_ESC_B = 8'hDD;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_ESC, S_EOF} state_e;

   state_e               state_q, state_d;
   logic [7:0]           out_data_q;
   logic                 out_valid_q;
   logic [7:0]           esc_q, esc_d;
   logic                 last_q, last_d;
   logic [CNT_WIDTH-1:0] cnt_q;

   logic       out_free;
   logic       in_avail;
   logic       pop_state;
   logic       pop;
   logic       is_esc;
   logic       load;
   logic [7:0] load_data;
   logic       cnt_inc;

   assign out_free  = ~out_valid_q | out_ready;
   assign in_avail  = out_free & ~in_empty;
   // With no leading END, IDLE pops the first byte exactly like DATA does.
   assign pop_state = (state_q == S_DATA) || ((state_q == S_IDLE) && !LEAD_END);
   assign pop       = in_avail & pop_state;
   assign in_ena    = ~rst & pop;
   assign is_esc    = (in_data == END_B) || (in_data == ESC_B);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (pop) begin
         if (is_esc) begin
            state_d = S_ESC;
         end else if (in_last) begin
            state_d = S_EOF;
         end else begin
            state_d = S_DATA;
         end
      end else begin
         case (state_q)
            S_IDLE:  if (in_avail) state_d = S_DATA;
            S_ESC:   if (out_free) state_d = last_q ? S_EOF : S_DATA;
            S_EOF:   if (out_free) state_d = S_IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      load      = 1'b0;
      load_data = '0;
      esc_d     = esc_q;
      last_d    = last_q;
      cnt_inc   = 1'b0;
      if (pop) begin
         load = 1'b1;
         if (is_esc) begin
            load_data = ESC_B;
            esc_d     = (in_data == END_B) ? ESC_END_B : ESC_ESC_B;
            last_d    = in_last;
         end else begin
            load_data = in_data;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_avail) begin
                  load      = 1'b1;
                  load_data = END_B;
               end
            end
            S_ESC: begin
               if (out_free) begin
                  load      = 1'b1;
                  load_data = esc_q;
               end
            end
            S_EOF: begin
               if (out_free) begin
                  load      = 1'b1;
                  load_data = END_B;
                  cnt_inc   = 1'b1;
               end
            end
            default: begin
               load = 1'b0;
            end
         endcase
      end
   end

   // Output register only moves when the sink can take a byte; otherwise it holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         esc_q       <= '0;
         last_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         if (out_free) begin
            out_valid_q <= load;
            if (load) begin
               out_data_q <= load_data;
            end
         end
         esc_q  <= esc_d;
         last_q <= last_d;
         if (cnt_inc) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q != S_IDLE);
   assign frm_cnt   = cnt_q;

endmodule

// File: tb/tb_slip_tx_enc.sv
// Scoreboard bench for slip_tx_enc: one instance with leading END, one without
// (2-bit frame counter) to exercise back-to-back frames and counter wrap.
module tb_slip_tx_enc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [7:0]  in_data_a, out_data_a, in_data_b, out_data_b;
   logic        in_last_a, in_empty_a, in_ena_a, out_valid_a, out_ready_a, busy_a;
   logic        in_last_b, in_empty_b, in_ena_b, out_valid_b, out_ready_b, busy_b;
   logic [15:0] frm_cnt_a;
   logic [1:0]  frm_cnt_b;

   slip_tx_enc #(.LEAD_END(1'b1), .CNT_WIDTH(16)) dut_a (
      .clk(clk), .rst(rst), .in_data(in_data_a), .in_last(in_last_a),
      .in_empty(in_empty_a), .in_ena(in_ena_a), .out_data(out_data_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .busy(busy_a),
      .frm_cnt(frm_cnt_a));

   slip_tx_enc #(.LEAD_END(1'b0), .CNT_WIDTH(2)) dut_b (
      .clk(clk), .rst(rst), .in_data(in_data_b), .in_last(in_last_b),
      .in_empty(in_empty_b), .in_ena(in_ena_b), .out_data(out_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .busy(busy_b),
      .frm_cnt(frm_cnt_b));

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [8:0] fa[$], fb[$];
   logic [7:0] ea[$], eb[$];
   int pops_a = 0, pops_b = 0;
   int acc_n_a = 0, acc_first_a = 0, acc_last_a = 0;
   int acc_n_b = 0, acc_first_b = 0, acc_last_b = 0;
   int frames_b = 0;
   logic ena_s_a = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic present();
      in_empty_a = (fa.size() == 0);
      in_data_a  = (fa.size() != 0) ? fa[0][7:0] : 8'h00;
      in_last_a  = (fa.size() != 0) ? fa[0][8] : 1'b0;
      in_empty_b = (fb.size() == 0);
      in_data_b  = (fb.size() != 0) ? fb[0][7:0] : 8'h00;
      in_last_b  = (fb.size() != 0) ? fb[0][8] : 1'b0;
   endtask

   // FIFO model: pop decision sampled mid-cycle, applied just after the edge.
   task automatic tick();
      logic pa, pb;
      @(negedge clk);
      pa = in_ena_a;
      pb = in_ena_b;
      ena_s_a = pa;
      @(posedge clk);
      #1;
      if (pa) begin
         if (fa.size() != 0) void'(fa.pop_front());
         pops_a++;
      end
      if (pb) begin
         if (fb.size() != 0) void'(fb.pop_front());
         pops_b++;
      end
      present();
   endtask

   task automatic pa(input logic [7:0] d, input logic l); fa.push_back({l, d}); endtask
   task automatic pb(input logic [7:0] d, input logic l); fb.push_back({l, d}); endtask
   task automatic xa(input logic [7:0] d); ea.push_back(d); endtask
   task automatic xb(input logic [7:0] d); eb.push_back(d); endtask

   task automatic drain(input string name);
      int n = 0;
      while ((ea.size() != 0 || eb.size() != 0 || out_valid_a || busy_a ||
              out_valid_b || busy_b) && n < 200) begin
         tick();
         n++;
      end
      check(name, 32'(n < 200), 32'd1);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor A: scoreboard compare plus hold-under-backpressure check.
   initial begin
      logic pv, pr, prst;
      logic [7:0] pd;
      pv = 1'b0; pr = 1'b1; prst = 1'b1; pd = 8'h00;
      forever begin
         @(negedge clk);
         if (pv && !pr && !prst) begin
            check("a_hold_valid", 32'(out_valid_a), 32'd1);
            check("a_hold_data", 32'(out_data_a), 32'(pd));
         end
         if (out_valid_a && out_ready_a) begin
            if (ea.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL a_unexpected: got %0h expected no byte", out_data_a);
            end else begin
               check("a_byte", 32'(out_data_a), 32'(ea.pop_front()));
            end
            if (acc_n_a == 0) acc_first_a = cyc;
            acc_last_a = cyc;
            acc_n_a++;
         end
         pv = out_valid_a; pr = out_ready_a; pd = out_data_a; prst = rst;
      end
   end

   // Monitor B: scoreboard compare plus frame counter after each END.
   initial forever begin
      @(negedge clk);
      if (out_valid_b && out_ready_b) begin
         if (eb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected: got %0h expected no byte", out_data_b);
         end else begin
            check("b_byte", 32'(out_data_b), 32'(eb.pop_front()));
         end
         if (out_data_b == 8'hC0) begin
            frames_b++;
            check("b_frm_cnt", 32'(frm_cnt_b), 32'(frames_b % 4));
         end
         if (acc_n_b == 0) acc_first_b = cyc;
         acc_last_b = cyc;
         acc_n_b++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      out_ready_a = 1'b1;
      out_ready_b = 1'b1;
      present();
      tick();
      tick();
      rst = 1'b0;
      check("rst_valid", 32'(out_valid_a), 32'd0);
      check("rst_data", 32'(out_data_a), 32'h00);
      check("rst_cnt_a", 32'(frm_cnt_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_cnt_b", 32'(frm_cnt_b), 32'd0);

      // 1: plain packet, full throughput
      pops_a = 0; acc_n_a = 0;
      pa(8'h11, 1'b0); pa(8'h22, 1'b0); pa(8'h33, 1'b1);
      xa(8'hC0); xa(8'h11); xa(8'h22); xa(8'h33); xa(8'hC0);
      present();
      drain("t1_drain");
      check("t1_pops", 32'(pops_a), 32'd3);
      check("t1_beats", 32'(acc_n_a), 32'd5);
      check("t1_span", 32'(acc_last_a - acc_first_a), 32'd4);
      check("t1_cnt", 32'(frm_cnt_a), 32'd1);

      // 2: both escapes
      pops_a = 0; acc_n_a = 0;
      pa(8'hC0, 1'b0); pa(8'hDB, 1'b1);
      xa(8'hC0); xa(8'hDB); xa(8'hDC); xa(8'hDB); xa(8'hDD); xa(8'hC0);
      present();
      drain("t2_drain");
      check("t2_pops", 32'(pops_a), 32'd2);
      check("t2_span", 32'(acc_last_a - acc_first_a), 32'd5);
      check("t2_cnt", 32'(frm_cnt_a), 32'd2);

      // 3: backpressure mid-packet
      pops_a = 0;
      pa(8'h01, 1'b0); pa(8'h02, 1'b0); pa(8'h03, 1'b0); pa(8'h04, 1'b1);
      xa(8'hC0); xa(8'h01); xa(8'h02); xa(8'h03); xa(8'h04); xa(8'hC0);
      present();
      tick();
      tick();
      out_ready_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t3_ena", 32'(ena_s_a), 32'd0);
         check("t3_data", 32'(out_data_a), 32'h01);
      end
      out_ready_a = 1'b1;
      drain("t3_drain");
      check("t3_pops", 32'(pops_a), 32'd4);
      check("t3_cnt", 32'(frm_cnt_a), 32'd3);

      // 4: FIFO underrun between bytes 2 and 3
      pops_a = 0;
      pa(8'h21, 1'b0); pa(8'h22, 1'b0);
      xa(8'hC0); xa(8'h21); xa(8'h22); xa(8'h23); xa(8'hC0);
      present();
      tick(); tick(); tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_bubble", 32'(out_valid_a), 32'd0);
         check("t4_busy", 32'(busy_a), 32'd1);
      end
      pa(8'h23, 1'b1);
      present();
      drain("t4_drain");
      check("t4_pops", 32'(pops_a), 32'd3);
      check("t4_cnt", 32'(frm_cnt_a), 32'd4);

      // 5: reset while in ESC with a held byte
      pa(8'h11, 1'b0); pa(8'hC0, 1'b1);
      xa(8'hC0); xa(8'h11);
      present();
      tick(); tick(); tick();
      check("t5_pre_valid", 32'(out_valid_a), 32'd1);
      check("t5_pre_data", 32'(out_data_a), 32'hDB);
      check("t5_pre_busy", 32'(busy_a), 32'd1);
      out_ready_a = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready_a = 1'b1;
      check("t5_valid", 32'(out_valid_a), 32'd0);
      check("t5_cnt", 32'(frm_cnt_a), 32'd0);
      check("t5_busy", 32'(busy_a), 32'd0);
      pa(8'h55, 1'b1);
      xa(8'hC0); xa(8'h55); xa(8'hC0);
      present();
      drain("t5_drain");
      check("t5_cnt_after", 32'(frm_cnt_a), 32'd1);

      // 6: trailing END only, back-to-back single-byte frames, counter wrap
      pops_b = 0; acc_n_b = 0;
      for (int i = 0; i < 5; i++) begin
         pb(8'hAA, 1'b1);
         xb(8'hAA);
         xb(8'hC0);
      end
      present();
      drain("t6_drain");
      check("t6_pops", 32'(pops_b), 32'd5);
      check("t6_beats", 32'(acc_n_b), 32'd10);
      check("t6_span", 32'(acc_last_b - acc_first_b), 32'd9);
      check("t6_cnt", 32'(frm_cnt_b), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
